// File: rtl/tone_player.sv
// Queued square-wave note player: {half-period, duration} notes enter a FIFO and play back-to-back.
// Optional TONE_PLAYER_ABORT_EN adds an abort input that flushes the queue and stops playback.
module tone_player #(
    parameter int HALF_W     = 16,
    parameter int DUR_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
`ifdef TONE_PLAYER_ABORT_EN
    input  logic              abort,
`endif
    input  logic              note_valid,
    output logic              note_ready,
    input  logic [HALF_W-1:0] note_half,
    input  logic [DUR_W-1:0]  note_dur,
    input  logic              mute,
    output logic              speaker,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int NOTE_W = HALF_W + DUR_W;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t state, state_nxt;

    logic [NOTE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [HALF_W-1:0] half_reg, half_cnt;
    logic [DUR_W-1:0]  dur_reg, dur_cnt, dur_last;
    logic              tone, tone_nxt, speaker_nxt, done_nxt;
    logic              abort_now, push, pop, load;
    logic              fifo_empty, fifo_full, note_end, toggle_hit;

`ifdef TONE_PLAYER_ABORT_EN
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign note_ready = !fifo_full;
    assign push       = note_valid && note_ready && !abort_now;
    assign busy       = (state == PLAY) || !fifo_empty;

    // A zero duration behaves as a one-cycle note.
    assign dur_last   = (dur_reg == '0) ? '0 : dur_reg - DUR_W'(1);
    assign note_end   = (state == PLAY) && (dur_cnt == dur_last);
    assign toggle_hit = (state == PLAY) && (half_reg != '0) &&
                        (half_cnt == half_reg - HALF_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (note_end) begin
                    if (!fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_now) begin
            state_nxt = IDLE;
            pop       = 1'b0;
            load      = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_comb begin
        tone_nxt = tone;
        if (toggle_hit) begin
            tone_nxt = ~tone;
        end
        if (load || state_nxt == IDLE) begin
            tone_nxt = 1'b0;
        end
        speaker_nxt = tone_nxt && !mute && (state_nxt == PLAY);
    end

    always_ff @(posedge clock) begin
        if (reset || abort_now) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {note_half, note_dur};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            half_reg <= '0;
            dur_reg  <= '0;
            half_cnt <= '0;
            dur_cnt  <= '0;
            tone     <= 1'b0;
            speaker  <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (load) begin
                {half_reg, dur_reg} <= mem[rd_ptr];
                half_cnt <= '0;
                dur_cnt  <= '0;
            end else if (state_nxt == PLAY) begin
                dur_cnt  <= dur_cnt + DUR_W'(1);
                half_cnt <= toggle_hit ? '0 : half_cnt + HALF_W'(1);
            end else begin
                half_cnt <= '0;
                dur_cnt  <= '0;
            end
            tone    <= tone_nxt;
            speaker <= speaker_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player: single-note vector table plus multi-note, reset and abort sequences.
module tb_tone_player;

    logic        clock = 1'b0;
    logic        reset;
    logic        note_valid;
    logic        note_ready;
    logic [15:0] note_half;
    logic [23:0] note_dur;
    logic        mute;
    logic        speaker;
    logic        busy;
    logic        done;
`ifdef TONE_PLAYER_ABORT_EN
    logic        abort;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_total = 0;

    tone_player #(.HALF_W(16), .DUR_W(24), .FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
`ifdef TONE_PLAYER_ABORT_EN
        .abort      (abort),
`endif
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_half  (note_half),
        .note_dur   (note_dur),
        .mute       (mute),
        .speaker    (speaker),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done) done_total++;
    end

    typedef struct {
        int half;
        int dur;
        bit m;
        int first;
        int rises;
        int high;
        int done_at;
    } vec_t;

    vec_t tbl [7];

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_one(input int h, input int d);
        note_half  = 16'(h);
        note_dur   = 24'(d);
        note_valid = 1'b1;
        step();
        note_valid = 1'b0;
    endtask

    initial begin
        int first, rises, high, done_at, dcnt, busyc, dur_eff, waits, e1, dc, exp_sp, mism, busy_hi;
        bit prev;

        tbl[0] = '{half:5, dur:40, m:0, first:5,  rises:4, high:20, done_at:40};
        tbl[1] = '{half:4, dur:32, m:1, first:-1, rises:0, high:0,  done_at:32};
        tbl[2] = '{half:0, dur:10, m:0, first:-1, rises:0, high:0,  done_at:10};
        tbl[3] = '{half:3, dur:12, m:0, first:3,  rises:2, high:6,  done_at:12};
        tbl[4] = '{half:1, dur:6,  m:0, first:1,  rises:3, high:3,  done_at:6};
        tbl[5] = '{half:7, dur:0,  m:0, first:-1, rises:0, high:0,  done_at:1};
        tbl[6] = '{half:2, dur:5,  m:0, first:2,  rises:1, high:2,  done_at:5};

        reset = 1'b1; note_valid = 1'b0; note_half = '0; note_dur = '0; mute = 1'b0;
`ifdef TONE_PLAYER_ABORT_EN
        abort = 1'b0;
`endif
        step(); step();
        chk("rst_speaker", int'(speaker), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(note_ready), 1);
        reset = 1'b0;
        step();

        // Single-note vectors: offsets n are counted in edges after the pop edge E1.
        for (int i = 0; i < 7; i++) begin
            mute = tbl[i].m;
            push_one(tbl[i].half, tbl[i].dur);
            dur_eff = (tbl[i].dur == 0) ? 1 : tbl[i].dur;
            first = -1; rises = 0; high = 0; done_at = -1; dcnt = 0; busyc = 0; prev = 1'b0;
            for (int n = 0; n < dur_eff + 3; n++) begin
                step();
                if (speaker) begin
                    high++;
                    if (!prev) begin
                        rises++;
                        if (first < 0) first = n;
                    end
                end
                prev = speaker;
                if (done) begin
                    dcnt++;
                    done_at = n;
                end
                if (busy && n < dur_eff) busyc++;
            end
            chk($sformatf("v%0d_first_rise", i), first, tbl[i].first);
            chk($sformatf("v%0d_rises", i), rises, tbl[i].rises);
            chk($sformatf("v%0d_high", i), high, tbl[i].high);
            chk($sformatf("v%0d_done_at", i), done_at, tbl[i].done_at);
            chk($sformatf("v%0d_done_cnt", i), dcnt, 1);
            chk($sformatf("v%0d_busy_cycles", i), busyc, dur_eff);
            chk($sformatf("v%0d_busy_end", i), int'(busy), 0);
            chk($sformatf("v%0d_ready_end", i), int'(note_ready), 1);
            mute = 1'b0;
        end

        // Fill the queue behind a playing note; the sixth push must stall until a pop.
        dc = done_total;
        push_one(2, 20);
        step();
        e1 = cyc;
        for (int k = 0; k < 4; k++) push_one(3, 6);
        chk("fill_ready_low", int'(note_ready), 0);
        note_half = 16'd3; note_dur = 24'd6; note_valid = 1'b1;
        waits = 0;
        while (!note_ready && waits < 100) begin
            step();
            waits++;
        end
        chk("fill_stall_cycles", waits, 16);
        step();
        note_valid = 1'b0;
        while (!done && (cyc - e1) < 200) step();
        chk("fill_done_at", cyc - e1, 50);
        step(); step();
        chk("fill_done_pulses", done_total - dc, 1);
        chk("fill_busy_end", int'(busy), 0);

        // Rest followed by a tone, checked cycle by cycle.
        push_one(0, 10);
        push_one(3, 12);
        mism = 0; busy_hi = 0; done_at = -1;
        for (int n = 0; n < 26; n++) begin
            if (n > 0) step();
            exp_sp = (n >= 10 && n < 22 && (((n - 10) / 3) % 2) == 1) ? 1 : 0;
            if (int'(speaker) != exp_sp) mism++;
            if (busy) busy_hi++;
            if (done) done_at = n;
        end
        chk("rest_tone_speaker_mism", mism, 0);
        chk("rest_tone_busy_cycles", busy_hi, 22);
        chk("rest_tone_done_at", done_at, 22);

        // Reset mid-note with two notes queued.
        push_one(4, 40);
        push_one(4, 10);
        push_one(4, 10);
        for (int k = 0; k < 5; k++) step();
        chk("pre_rst_busy", int'(busy), 1);
        dc = done_total;
        reset = 1'b1;
        step();
        chk("mid_rst_speaker", int'(speaker), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(note_ready), 1);
        reset = 1'b0;
        for (int k = 0; k < 60; k++) step();
        chk("mid_rst_no_done", done_total - dc, 0);
        chk("mid_rst_busy_after", int'(busy), 0);

`ifdef TONE_PLAYER_ABORT_EN
        // Abort with three queued and a coincident push that must be dropped.
        push_one(3, 30);
        push_one(3, 30);
        push_one(3, 30);
        push_one(3, 30);
        for (int k = 0; k < 4; k++) step();
        dc = done_total;
        abort = 1'b1;
        note_half = 16'd2; note_dur = 24'd8; note_valid = 1'b1;
        #1;
        chk("abort_ready_same_cycle", int'(note_ready), 1);
        step();
        abort = 1'b0; note_valid = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_speaker", int'(speaker), 0);
        for (int k = 0; k < 40; k++) step();
        chk("abort_no_done", done_total - dc, 0);
        chk("abort_stays_idle", int'(busy), 0);
        push_one(2, 8);
        done_at = -1;
        for (int n = 0; n < 12; n++) begin
            step();
            if (done && done_at < 0) done_at = n;
        end
        chk("abort_later_done_at", done_at, 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
